// File: rtl/read_burst_collector.sv
// Collects DIMM read bursts into whole cache lines. Outstanding reads are queued with their issue time.
// Each read's beats are sampled CAS_LATENCY cycles after issue and unwrapped from critical-word-first order.
module read_burst_collector #(
  parameter int          CAS_LATENCY = 22,
  parameter int          BURST_LEN   = 8,
  parameter int          DATA_WIDTH  = 64,
  parameter int          PADDR_BITS  = 64,
  parameter int          COL_BITS    = 4,
  parameter int          QUEUE_DEPTH = 16,
  parameter logic [31:0] CNT_INIT    = 32'h0
) (
  input  logic                             clk_in,
  input  logic                             rst_N_in,
  input  logic                             issue_valid_in,
  input  logic [PADDR_BITS-1:0]            issue_paddr_in,
  input  logic [COL_BITS-1:0]              issue_col_in,
  output logic                             issue_ready_out,
  input  logic [DATA_WIDTH-1:0]            mem_bus_data_in,
  output logic                             bursting_out,
  output logic                             line_valid_out,
  input  logic                             line_ready_in,
  output logic [PADDR_BITS-1:0]            line_paddr_out,
  output logic [BURST_LEN*DATA_WIDTH-1:0]  line_data_out,
  output logic [$clog2(QUEUE_DEPTH):0]     pending_count_out,
  output logic                             overrun_err_out,
  output logic                             collision_err_out
);

  localparam int PTR_W  = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W  = $clog2(QUEUE_DEPTH) + 1;
  localparam int IDX_W  = $clog2(BURST_LEN);
  localparam int LINE_W = BURST_LEN * DATA_WIDTH;

  localparam logic [0:0]       ST_IDLE    = 1'b0;
  localparam logic [0:0]       ST_CAPTURE = 1'b1;
  localparam logic [31:0]      DUE_AGE    = 32'(CAS_LATENCY - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(QUEUE_DEPTH);

  logic [31:0]           cyc_cnt;
  logic [PADDR_BITS-1:0] q_paddr [QUEUE_DEPTH];
  logic [IDX_W-1:0]      q_off   [QUEUE_DEPTH];
  logic [31:0]           q_stamp [QUEUE_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr, cand_ptr;
  logic [CNT_W-1:0]      count;

  logic [0:0]            state;
  logic [IDX_W-1:0]      beat_idx, wr_idx;
  logic [PADDR_BITS-1:0] cap_paddr_p1;
  logic [IDX_W-1:0]      cap_off_p1;
  logic [LINE_W-1:0]     line_buf, line_nxt;

  logic                  head_active, cand_ok, due, last_beat, start, collide, accept;
  logic [31:0]           cand_age;
  logic [1:0]            deq_n;

  // Only the low column bits select the unwrap offset.
  if (COL_BITS > IDX_W) begin : g_col_hi
    logic unused_col_hi;
    assign unused_col_hi = ^issue_col_in[COL_BITS-1:IDX_W];
  end

  assign issue_ready_out   = (count != FULL_CNT);
  assign accept            = issue_valid_in && issue_ready_out;
  assign bursting_out      = (state == ST_CAPTURE);
  assign pending_count_out = count;

  // While beat 0 is on the bus its entry is still the head, so the next read due is one slot behind it.
  assign head_active = (state == ST_CAPTURE) && (beat_idx == '0);
  assign cand_ptr    = rd_ptr + PTR_W'(head_active);
  assign cand_ok     = head_active ? (count > CNT_W'(1)) : (count != '0);
  assign cand_age    = cyc_cnt - q_stamp[cand_ptr];
  assign due         = cand_ok && (cand_age == DUE_AGE);
  assign last_beat   = (state == ST_CAPTURE) && (beat_idx == LAST_IDX);
  assign start       = due && ((state == ST_IDLE) || last_beat);
  assign collide     = due && (state == ST_CAPTURE) && !last_beat;
  assign deq_n       = {1'b0, head_active} + {1'b0, collide};

  assign wr_idx = cap_off_p1 + beat_idx;

  always_comb begin
    line_nxt = line_buf;
    line_nxt[int'(wr_idx)*DATA_WIDTH +: DATA_WIDTH] = mem_bus_data_in;
  end

  // ---- stage p0: queue bookkeeping, capture control, output slot ----
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      cyc_cnt           <= CNT_INIT;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      state             <= ST_IDLE;
      beat_idx          <= '0;
      line_valid_out    <= 1'b0;
      line_paddr_out    <= '0;
      line_data_out     <= '0;
      overrun_err_out   <= 1'b0;
      collision_err_out <= 1'b0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr <= rd_ptr + PTR_W'(deq_n);
      count  <= count + CNT_W'(accept) - CNT_W'(deq_n);

      if (start) begin
        state    <= ST_CAPTURE;
        beat_idx <= '0;
      end else if (last_beat) begin
        state    <= ST_IDLE;
      end else if (state == ST_CAPTURE) begin
        beat_idx <= beat_idx + IDX_W'(1);
      end

      if (collide) collision_err_out <= 1'b1;

      if (last_beat) begin
        if (!line_valid_out || line_ready_in) begin
          line_valid_out <= 1'b1;
          line_paddr_out <= cap_paddr_p1;
          line_data_out  <= line_nxt;
        end else begin
          overrun_err_out <= 1'b1;
        end
      end else if (line_ready_in) begin
        line_valid_out <= 1'b0;
      end
    end
  end

  // ---- stage p1: queue storage, capture context and beat assembly ----
  always_ff @(posedge clk_in) begin
    if (accept) begin
      q_paddr[wr_ptr] <= issue_paddr_in;
      q_off[wr_ptr]   <= issue_col_in[IDX_W-1:0];
      q_stamp[wr_ptr] <= cyc_cnt;
    end
    if (start) begin
      cap_paddr_p1 <= q_paddr[cand_ptr];
      cap_off_p1   <= q_off[cand_ptr];
    end
    if (state == ST_CAPTURE) line_buf <= line_nxt;
  end

endmodule
